miriscv_data_arbiter: RTL and testbench
=======================================

MIRISCV_DATA_ARBITER -- requirements
Module: miriscv_data_arbiter

Interface
REQ-001 SHALL have parameter OUTSTANDING, default 2, meaning the maximum number of issued memory requests awaiting data_rvalid_i (legal range 1..8).
REQ-002 SHALL have one clock and a synchronous, active-high reset.
REQ-003 clk_i  input  1  clock; all state updates on the rising edge.
REQ-004 rst_i  input  1  synchronous active-high reset.
REQ-005 core_req_i / core_we_i  input  1 / 1  core LSU request and write enable.
REQ-006 core_be_i / core_addr_i / core_wdata_i  input  XLEN/8 / XLEN / XLEN  core byte enables, address and write data.
REQ-007 core_gnt_o / core_rvalid_o / core_rdata_o  output  1 / 1 / XLEN  core grant, response valid and read data.
REQ-008 ext_req_i, ext_we_i, ext_be_i, ext_addr_i, ext_wdata_i, ext_gnt_o, ext_rvalid_o, ext_rdata_o  same directions and widths as core_*; external (debug/DMA) requester.
REQ-009 data_req_o, data_we_o, data_be_o, data_addr_o, data_wdata_o  output  1/1/XLEN/8/XLEN/XLEN  shared data memory port.
REQ-010 data_rvalid_i / data_rdata_i  input  1 / XLEN  memory responses, in issue order.
REQ-011 spurious_rsp_o  output  1  single-cycle pulse for data_rvalid_i with no outstanding request.

Function
REQ-012 A request SHALL be issued when at least one *_req_i is high and the owner FIFO holds fewer than OUTSTANDING entries (registered count only; no combinational path from data_rvalid_i to data_req_o).
REQ-013 Grant SHALL be combinational in the request cycle; data_req_o = core_gnt_o | ext_gnt_o; at most one grant per cycle.
REQ-014 data_we/be/addr/wdata_o SHALL carry the granted requester's fields; all zero when data_req_o is low.
REQ-015 Requesters SHALL hold req and fields stable until granted; an ungranted request is never dropped.
REQ-016 Each issue SHALL push the owner ID (CORE=0, EXT=1) into the owner FIFO.
REQ-017 Each data_rvalid_i with a non-empty FIFO SHALL pop the head and assert the owner's *_rvalid_o in the same cycle, with *_rdata_o = data_rdata_i; the other requester's rvalid stays low.
REQ-018 *_rdata_o SHALL be zero whenever the corresponding *_rvalid_o is low.
REQ-019 Simultaneous push and pop SHALL leave the count unchanged; when full, issue stalls even if data_rvalid_i is high that cycle.
REQ-020 data_rvalid_i with an empty FIFO SHALL pulse spurious_rsp_o, route nothing and leave state unchanged.
REQ-021 The FIFO pointers SHALL wrap modulo OUTSTANDING.

Reset
REQ-022 During reset, all outputs SHALL be 0; FIFO count, pointers and the round-robin last-grant register (value CORE) SHALL be cleared.
REQ-023 Reset asserted mid-transaction SHALL discard all outstanding entries; responses arriving after reset SHALL be treated as spurious.

Configuration
REQ-024 With MIRISCV_DATA_ARB_RR_EN defined, a conflict SHALL grant the requester not granted most recently; the last-grant register updates on every issue.
REQ-025 Without MIRISCV_DATA_ARB_RR_EN, a conflict SHALL always grant core, and the last-grant register SHALL NOT be implemented.

Structure
REQ-026 The owner-ID typedef (data_arb_owner_e: CORE, EXT) SHALL be placed in miriscv_lsu_pkg.
REQ-027 The owner FIFO SHALL be the sub-module miriscv_arb_id_fifo (1-bit data, depth OUTSTANDING, push/pop/full/empty).

Verification
REQ-028 Core read only to 0x100, rdata 0xDEADBEEF returned 3 cycles later -> core_gnt_o=1 in cycle 0; core_rvalid_o=1 with 0xDEADBEEF in cycle 3; ext_rvalid_o=0 throughout.
REQ-029 Core and ext request together for 4 cycles, RR_EN defined, reset just released -> grants alternate EXT, CORE, EXT, CORE; without RR_EN, core is granted each cycle.
REQ-030 OUTSTANDING=2, three back-to-back core reads, no rvalid -> two issues, third stalls with core_gnt_o=0; one rvalid -> third issues the next cycle, not the same cycle.
REQ-031 Interleaved issues core(0x10), ext(0x20), core(0x30), responses A/B/C in order -> core receives A and C, ext receives B.
REQ-032 data_rvalid_i with an empty FIFO -> spurious_rsp_o pulses for 1 cycle, no rvalid outputs; rst_i with 2 outstanding, then 2 rvalids -> 2 spurious pulses.

Source files
------------

// File: rtl/miriscv_lsu_pkg.sv
// Shared LSU types for the data-port arbiter: word geometry, owner IDs and the
// request bundle driven onto the shared memory port.
package miriscv_lsu_pkg;

    localparam int XLEN = 32;
    localparam int BE_W = XLEN / 8;

    typedef enum logic {
        CORE = 1'b0,
        EXT  = 1'b1
    } data_arb_owner_e;

    typedef struct packed {
        logic            we;
        logic [BE_W-1:0] be;
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] wdata;
    } data_req_t;

    function automatic data_req_t pack_req(
        input logic            we,
        input logic [BE_W-1:0] be,
        input logic [XLEN-1:0] addr,
        input logic [XLEN-1:0] wdata
    );
        data_req_t r;
        r.we    = we;
        r.be    = be;
        r.addr  = addr;
        r.wdata = wdata;
        return r;
    endfunction

endpackage

// File: rtl/miriscv_arb_id_fifo.sv
// Owner-ID FIFO: remembers which requester issued each outstanding memory
// request so in-order responses can be routed back. Pointers wrap modulo DEPTH.
import miriscv_lsu_pkg::*;

module miriscv_arb_id_fifo #(
    parameter int DEPTH = 2
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            push_i,
    input  data_arb_owner_e push_data_i,
    input  logic            pop_i,
    output data_arb_owner_e pop_data_o,
    output logic            full_o,
    output logic            empty_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [DEPTH-1:0] mem_r;
    logic [PTR_W-1:0] wptr_r;
    logic [PTR_W-1:0] rptr_r;
    logic [CNT_W-1:0] count_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign full_o     = (count_r == CNT_W'(DEPTH));
    assign empty_o    = (count_r == {CNT_W{1'b0}});
    assign push_ok_s  = push_i && !full_o;
    assign pop_ok_s   = pop_i && !empty_o;
    assign pop_data_o = data_arb_owner_e'(mem_r[rptr_r]);

    // Pointer, count and storage update; explicit wrap keeps non-power-of-two depths legal.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mem_r   <= {DEPTH{1'b0}};
            wptr_r  <= {PTR_W{1'b0}};
            rptr_r  <= {PTR_W{1'b0}};
            count_r <= {CNT_W{1'b0}};
        end else begin
            if (push_ok_s) begin
                mem_r[wptr_r] <= push_data_i;
                wptr_r        <= (wptr_r == PTR_W'(DEPTH - 1)) ? {PTR_W{1'b0}}
                                                               : wptr_r + PTR_W'(1);
            end
            if (pop_ok_s) begin
                rptr_r <= (rptr_r == PTR_W'(DEPTH - 1)) ? {PTR_W{1'b0}}
                                                        : rptr_r + PTR_W'(1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/miriscv_data_arbiter.sv
// Arbitrates core LSU and external requesters onto one data-memory port and
// routes in-order responses back. Define MIRISCV_DATA_ARB_RR_EN for round-robin on conflicts.
import miriscv_lsu_pkg::*;

module miriscv_data_arbiter #(
    parameter int OUTSTANDING = 2
) (
    input  logic            clk_i,
    input  logic            rst_i,

    input  logic            core_req_i,
    input  logic            core_we_i,
    input  logic [BE_W-1:0] core_be_i,
    input  logic [XLEN-1:0] core_addr_i,
    input  logic [XLEN-1:0] core_wdata_i,
    output logic            core_gnt_o,
    output logic            core_rvalid_o,
    output logic [XLEN-1:0] core_rdata_o,

    input  logic            ext_req_i,
    input  logic            ext_we_i,
    input  logic [BE_W-1:0] ext_be_i,
    input  logic [XLEN-1:0] ext_addr_i,
    input  logic [XLEN-1:0] ext_wdata_i,
    output logic            ext_gnt_o,
    output logic            ext_rvalid_o,
    output logic [XLEN-1:0] ext_rdata_o,

    output logic            data_req_o,
    output logic            data_we_o,
    output logic [BE_W-1:0] data_be_o,
    output logic [XLEN-1:0] data_addr_o,
    output logic [XLEN-1:0] data_wdata_o,
    input  logic            data_rvalid_i,
    input  logic [XLEN-1:0] data_rdata_i,

    output logic            spurious_rsp_o
);

    logic            fifo_full_s;
    logic            fifo_empty_s;
    data_arb_owner_e fifo_head_s;
    data_arb_owner_e push_owner_s;
    logic            core_gnt_s;
    logic            ext_gnt_s;
    logic            issue_s;
    logic            pop_s;
    data_req_t       sel_req_s;

`ifdef MIRISCV_DATA_ARB_RR_EN
    data_arb_owner_e last_gnt_r;

    // Remember who was served last so the next conflict goes to the other side.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_gnt_r <= CORE;
        end else if (issue_s) begin
            last_gnt_r <= push_owner_s;
        end else begin
            last_gnt_r <= last_gnt_r;
        end
    end
`endif

    // Grant selection; gated only by the registered FIFO count so rvalid never reaches data_req_o.
    always_comb begin
        core_gnt_s = 1'b0;
        ext_gnt_s  = 1'b0;
        if (!rst_i && !fifo_full_s) begin
            if (core_req_i && ext_req_i) begin
`ifdef MIRISCV_DATA_ARB_RR_EN
                if (last_gnt_r == CORE) begin
                    ext_gnt_s = 1'b1;
                end else begin
                    core_gnt_s = 1'b1;
                end
`else
                core_gnt_s = 1'b1;
`endif
            end else if (core_req_i) begin
                core_gnt_s = 1'b1;
            end else if (ext_req_i) begin
                ext_gnt_s = 1'b1;
            end else begin
                core_gnt_s = 1'b0;
            end
        end else begin
            core_gnt_s = 1'b0;
            ext_gnt_s  = 1'b0;
        end
    end

    assign issue_s      = core_gnt_s | ext_gnt_s;
    assign push_owner_s = ext_gnt_s ? EXT : CORE;

    // Forward the granted requester's fields; the port is all zero when idle.
    always_comb begin
        sel_req_s = '0;
        if (core_gnt_s) begin
            sel_req_s = pack_req(core_we_i, core_be_i, core_addr_i, core_wdata_i);
        end else if (ext_gnt_s) begin
            sel_req_s = pack_req(ext_we_i, ext_be_i, ext_addr_i, ext_wdata_i);
        end else begin
            sel_req_s = '0;
        end
    end

    assign core_gnt_o   = core_gnt_s;
    assign ext_gnt_o    = ext_gnt_s;
    assign data_req_o   = issue_s;
    assign data_we_o    = sel_req_s.we;
    assign data_be_o    = sel_req_s.be;
    assign data_addr_o  = sel_req_s.addr;
    assign data_wdata_o = sel_req_s.wdata;

    assign pop_s = !rst_i && data_rvalid_i && !fifo_empty_s;

    // Response routing: the FIFO head names the owner of the oldest outstanding request.
    always_comb begin
        core_rvalid_o  = 1'b0;
        ext_rvalid_o   = 1'b0;
        core_rdata_o   = {XLEN{1'b0}};
        ext_rdata_o    = {XLEN{1'b0}};
        spurious_rsp_o = 1'b0;
        if (pop_s) begin
            case (fifo_head_s)
                CORE: begin
                    core_rvalid_o = 1'b1;
                    core_rdata_o  = data_rdata_i;
                end
                EXT: begin
                    ext_rvalid_o = 1'b1;
                    ext_rdata_o  = data_rdata_i;
                end
                default: begin
                    core_rvalid_o = 1'b0;
                    ext_rvalid_o  = 1'b0;
                end
            endcase
        end else if (!rst_i && data_rvalid_i) begin
            spurious_rsp_o = 1'b1;
        end else begin
            spurious_rsp_o = 1'b0;
        end
    end

    miriscv_arb_id_fifo #(
        .DEPTH (OUTSTANDING)
    ) u_id_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (issue_s),
        .push_data_i (push_owner_s),
        .pop_i       (pop_s),
        .pop_data_o  (fifo_head_s),
        .full_o      (fifo_full_s),
        .empty_o     (fifo_empty_s)
    );

endmodule

// File: tb/tb_miriscv_data_arbiter.sv
// Directed self-checking bench for miriscv_data_arbiter (OUTSTANDING=2).
import miriscv_lsu_pkg::*;

module tb_miriscv_data_arbiter;

    logic            clk_i = 1'b0;
    logic            rst_i;
    logic            core_req_i, core_we_i, ext_req_i, ext_we_i;
    logic [BE_W-1:0] core_be_i, ext_be_i;
    logic [XLEN-1:0] core_addr_i, core_wdata_i, ext_addr_i, ext_wdata_i;
    logic            core_gnt_o, core_rvalid_o, ext_gnt_o, ext_rvalid_o;
    logic [XLEN-1:0] core_rdata_o, ext_rdata_o;
    logic            data_req_o, data_we_o;
    logic [BE_W-1:0] data_be_o;
    logic [XLEN-1:0] data_addr_o, data_wdata_o;
    logic            data_rvalid_i;
    logic [XLEN-1:0] data_rdata_i;
    logic            spurious_rsp_o;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk_i = ~clk_i;

    miriscv_data_arbiter #(.OUTSTANDING(2)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .core_req_i(core_req_i), .core_we_i(core_we_i), .core_be_i(core_be_i),
        .core_addr_i(core_addr_i), .core_wdata_i(core_wdata_i),
        .core_gnt_o(core_gnt_o), .core_rvalid_o(core_rvalid_o), .core_rdata_o(core_rdata_o),
        .ext_req_i(ext_req_i), .ext_we_i(ext_we_i), .ext_be_i(ext_be_i),
        .ext_addr_i(ext_addr_i), .ext_wdata_i(ext_wdata_i),
        .ext_gnt_o(ext_gnt_o), .ext_rvalid_o(ext_rvalid_o), .ext_rdata_o(ext_rdata_o),
        .data_req_o(data_req_o), .data_we_o(data_we_o), .data_be_o(data_be_o),
        .data_addr_o(data_addr_o), .data_wdata_o(data_wdata_o),
        .data_rvalid_i(data_rvalid_i), .data_rdata_i(data_rdata_i),
        .spurious_rsp_o(spurious_rsp_o)
    );

    task automatic idle_inputs();
        core_req_i = 1'b0; core_we_i = 1'b0; core_be_i = 4'h0;
        core_addr_i = 32'h0; core_wdata_i = 32'h0;
        ext_req_i = 1'b0; ext_we_i = 1'b0; ext_be_i = 4'h0;
        ext_addr_i = 32'h0; ext_wdata_i = 32'h0;
        data_rvalid_i = 1'b0; data_rdata_i = 32'h0;
    endtask

    // Inputs change on the falling edge; outputs are sampled 1ns later.
    task automatic next_cycle();
        @(negedge clk_i);
    endtask

    task automatic do_reset();
        next_cycle();
        idle_inputs();
        rst_i = 1'b1;
        next_cycle();
        rst_i = 1'b0;
    endtask

    task automatic test_reset();
        next_cycle();
        rst_i = 1'b1;
        core_req_i = 1'b1; core_addr_i = 32'h0000_0100; core_be_i = 4'hF;
        ext_req_i = 1'b1; ext_addr_i = 32'h0000_0200;
        data_rvalid_i = 1'b1; data_rdata_i = 32'h1234_5678;
        #1;
        n_cmp++;
        if ({core_gnt_o, ext_gnt_o, data_req_o, spurious_rsp_o} !== 4'b0000) begin
            $display("FAIL reset_ctrl: got %b want 0000", {core_gnt_o, ext_gnt_o, data_req_o, spurious_rsp_o});
            n_err++;
        end
        n_cmp++;
        if ({core_rvalid_o, ext_rvalid_o, core_rdata_o, ext_rdata_o} !== 66'h0) begin
            $display("FAIL reset_rsp: got rv=%b%b rdata=%h/%h want all zero",
                     core_rvalid_o, ext_rvalid_o, core_rdata_o, ext_rdata_o);
            n_err++;
        end
        n_cmp++;
        if ({data_we_o, data_be_o, data_addr_o, data_wdata_o} !== 69'h0) begin
            $display("FAIL reset_port: got addr=%h be=%h want zero", data_addr_o, data_be_o);
            n_err++;
        end
        next_cycle();
        idle_inputs();
        rst_i = 1'b0;
    endtask

    task automatic test_single_read();
        next_cycle();
        core_req_i = 1'b1; core_we_i = 1'b0; core_be_i = 4'hF; core_addr_i = 32'h0000_0100;
        #1;
        n_cmp++;
        if ({core_gnt_o, ext_gnt_o, data_req_o, data_we_o, data_be_o, data_addr_o} !== {4'b1010, 4'hF, 32'h0000_0100}) begin
            $display("FAIL single_issue: got gnt=%b%b req=%b we=%b be=%h addr=%h want 10 1 0 f 00000100",
                     core_gnt_o, ext_gnt_o, data_req_o, data_we_o, data_be_o, data_addr_o);
            n_err++;
        end
        for (int c = 1; c <= 4; c++) begin
            next_cycle();
            idle_inputs();
            if (c == 3) begin
                data_rvalid_i = 1'b1; data_rdata_i = 32'hDEAD_BEEF;
            end
            #1;
            n_cmp++;
            if ({core_rvalid_o, ext_rvalid_o, core_rdata_o, ext_rdata_o, spurious_rsp_o} !==
                {(c == 3), 1'b0, ((c == 3) ? 32'hDEAD_BEEF : 32'h0), 32'h0, 1'b0}) begin
                $display("FAIL single_rsp_c%0d: got rv=%b%b rdata=%h ext=%h sp=%b", c,
                         core_rvalid_o, ext_rvalid_o, core_rdata_o, ext_rdata_o, spurious_rsp_o);
                n_err++;
            end
        end
        n_cmp++;
        if ({data_req_o, data_addr_o} !== 33'h0) begin
            $display("FAIL single_idle_port: got req=%b addr=%h want 0", data_req_o, data_addr_o);
            n_err++;
        end
    endtask

    task automatic test_conflict();
        logic rr_mode;
        logic exp_ext;
        logic prev_ext;
`ifdef MIRISCV_DATA_ARB_RR_EN
        rr_mode = 1'b1;
`else
        rr_mode = 1'b0;
`endif
        do_reset();
        prev_ext = 1'b0;
        for (int c = 0; c <= 4; c++) begin
            next_cycle();
            idle_inputs();
            exp_ext = rr_mode && (c % 2 == 0);
            if (c < 4) begin
                core_req_i = 1'b1; core_be_i = 4'h3; core_addr_i = 32'h200 + 32'(c * 4);
                ext_req_i = 1'b1; ext_we_i = 1'b1; ext_be_i = 4'hC;
                ext_addr_i = 32'h300 + 32'(c * 4); ext_wdata_i = 32'hE0 + 32'(c);
            end
            if (c > 0) begin
                data_rvalid_i = 1'b1; data_rdata_i = 32'h50 + 32'(c);
            end
            #1;
            if (c < 4) begin
                n_cmp++;
                if ({core_gnt_o, ext_gnt_o, data_req_o, data_we_o, data_addr_o} !==
                    {~exp_ext, exp_ext, 1'b1, exp_ext, (exp_ext ? 32'h300 + 32'(c * 4) : 32'h200 + 32'(c * 4))}) begin
                    $display("FAIL conflict_gnt_c%0d: got gnt=%b%b we=%b addr=%h want ext=%b", c,
                             core_gnt_o, ext_gnt_o, data_we_o, data_addr_o, exp_ext);
                    n_err++;
                end
            end
            if (c > 0) begin
                n_cmp++;
                if ({core_rvalid_o, ext_rvalid_o} !== {~prev_ext, prev_ext}) begin
                    $display("FAIL conflict_rsp_c%0d: got rv=%b%b want ext=%b", c,
                             core_rvalid_o, ext_rvalid_o, prev_ext);
                    n_err++;
                end
            end
            prev_ext = exp_ext;
        end
    endtask

    task automatic test_back_to_back();
        logic [XLEN-1:0] addr_q [3];
        addr_q[0] = 32'h40; addr_q[1] = 32'h44; addr_q[2] = 32'h48;
        next_cycle(); idle_inputs();
        core_req_i = 1'b1; core_be_i = 4'hF; core_addr_i = addr_q[0];
        #1;
        n_cmp++;
        if ({core_gnt_o, data_addr_o} !== {1'b1, addr_q[0]}) begin
            $display("FAIL b2b_issue0: got gnt=%b addr=%h", core_gnt_o, data_addr_o); n_err++;
        end
        next_cycle(); core_addr_i = addr_q[1];
        #1;
        n_cmp++;
        if ({core_gnt_o, data_addr_o} !== {1'b1, addr_q[1]}) begin
            $display("FAIL b2b_issue1: got gnt=%b addr=%h", core_gnt_o, data_addr_o); n_err++;
        end
        next_cycle(); core_addr_i = addr_q[2];
        #1;
        n_cmp++;
        if ({core_gnt_o, data_req_o, data_addr_o} !== 34'h0) begin
            $display("FAIL b2b_full_stall: got gnt=%b req=%b addr=%h want 0", core_gnt_o, data_req_o, data_addr_o);
            n_err++;
        end
        next_cycle(); data_rvalid_i = 1'b1; data_rdata_i = 32'h11;
        #1;
        n_cmp++;
        if ({core_gnt_o, data_req_o, core_rvalid_o, core_rdata_o} !== {3'b001, 32'h11}) begin
            $display("FAIL b2b_pop_no_issue: got gnt=%b req=%b rv=%b rdata=%h want 0 0 1 00000011",
                     core_gnt_o, data_req_o, core_rvalid_o, core_rdata_o);
            n_err++;
        end
        next_cycle(); data_rvalid_i = 1'b0; data_rdata_i = 32'h0;
        #1;
        n_cmp++;
        if ({core_gnt_o, data_addr_o} !== {1'b1, addr_q[2]}) begin
            $display("FAIL b2b_issue2: got gnt=%b addr=%h", core_gnt_o, data_addr_o); n_err++;
        end
        for (int k = 0; k < 2; k++) begin
            next_cycle(); idle_inputs();
            data_rvalid_i = 1'b1; data_rdata_i = 32'h22 + 32'(k * 17);
            #1;
            n_cmp++;
            if ({core_rvalid_o, spurious_rsp_o, core_rdata_o} !== {2'b10, 32'h22 + 32'(k * 17)}) begin
                $display("FAIL b2b_drain%0d: got rv=%b sp=%b rdata=%h", k, core_rvalid_o, spurious_rsp_o, core_rdata_o);
                n_err++;
            end
        end
    endtask

    task automatic test_interleave();
        next_cycle(); idle_inputs();
        core_req_i = 1'b1; core_addr_i = 32'h10;
        #1;
        n_cmp++;
        if ({core_gnt_o, ext_gnt_o, data_addr_o} !== {2'b10, 32'h10}) begin
            $display("FAIL il_core0: got gnt=%b%b addr=%h", core_gnt_o, ext_gnt_o, data_addr_o); n_err++;
        end
        next_cycle(); idle_inputs();
        ext_req_i = 1'b1; ext_addr_i = 32'h20;
        #1;
        n_cmp++;
        if ({core_gnt_o, ext_gnt_o, data_addr_o} !== {2'b01, 32'h20}) begin
            $display("FAIL il_ext: got gnt=%b%b addr=%h", core_gnt_o, ext_gnt_o, data_addr_o); n_err++;
        end
        next_cycle(); idle_inputs();
        core_req_i = 1'b1; core_addr_i = 32'h30;
        data_rvalid_i = 1'b1; data_rdata_i = 32'hA;
        #1;
        n_cmp++;
        if ({core_gnt_o, core_rvalid_o, ext_rvalid_o, core_rdata_o, ext_rdata_o} !== {3'b010, 32'hA, 32'h0}) begin
            $display("FAIL il_rsp_a: got gnt=%b rv=%b%b rdata=%h/%h", core_gnt_o, core_rvalid_o,
                     ext_rvalid_o, core_rdata_o, ext_rdata_o);
            n_err++;
        end
        next_cycle(); data_rdata_i = 32'hB;
        #1;
        n_cmp++;
        if ({core_gnt_o, data_addr_o, core_rvalid_o, ext_rvalid_o, core_rdata_o, ext_rdata_o} !==
            {1'b1, 32'h30, 2'b01, 32'h0, 32'hB}) begin
            $display("FAIL il_rsp_b: got gnt=%b addr=%h rv=%b%b rdata=%h/%h", core_gnt_o, data_addr_o,
                     core_rvalid_o, ext_rvalid_o, core_rdata_o, ext_rdata_o);
            n_err++;
        end
        next_cycle(); idle_inputs();
        data_rvalid_i = 1'b1; data_rdata_i = 32'hC;
        #1;
        n_cmp++;
        if ({core_rvalid_o, ext_rvalid_o, core_rdata_o, ext_rdata_o} !== {2'b10, 32'hC, 32'h0}) begin
            $display("FAIL il_rsp_c: got rv=%b%b rdata=%h/%h", core_rvalid_o, ext_rvalid_o, core_rdata_o, ext_rdata_o);
            n_err++;
        end
    endtask

    task automatic test_spurious();
        next_cycle(); idle_inputs();
        data_rvalid_i = 1'b1; data_rdata_i = 32'h77;
        #1;
        n_cmp++;
        if ({spurious_rsp_o, core_rvalid_o, ext_rvalid_o, core_rdata_o} !== {3'b100, 32'h0}) begin
            $display("FAIL sp_empty: got sp=%b rv=%b%b rdata=%h want 1 00 0", spurious_rsp_o,
                     core_rvalid_o, ext_rvalid_o, core_rdata_o);
            n_err++;
        end
        next_cycle(); idle_inputs();
        #1;
        n_cmp++;
        if (spurious_rsp_o !== 1'b0) begin
            $display("FAIL sp_one_cycle: got %b want 0", spurious_rsp_o); n_err++;
        end
        for (int k = 0; k < 2; k++) begin
            next_cycle(); core_req_i = 1'b1; core_addr_i = 32'h80 + 32'(k * 4);
            #1;
            n_cmp++;
            if (core_gnt_o !== 1'b1) begin
                $display("FAIL sp_fill%0d: got gnt=%b want 1", k, core_gnt_o); n_err++;
            end
        end
        next_cycle(); rst_i = 1'b1;
        #1;
        n_cmp++;
        if ({core_gnt_o, data_req_o} !== 2'b00) begin
            $display("FAIL sp_in_reset: got gnt=%b req=%b want 00", core_gnt_o, data_req_o); n_err++;
        end
        for (int k = 0; k < 2; k++) begin
            next_cycle(); idle_inputs(); rst_i = 1'b0;
            data_rvalid_i = 1'b1; data_rdata_i = 32'h90 + 32'(k);
            #1;
            n_cmp++;
            if ({spurious_rsp_o, core_rvalid_o, ext_rvalid_o} !== 3'b100) begin
                $display("FAIL sp_after_reset%0d: got sp=%b rv=%b%b want 1 00", k,
                         spurious_rsp_o, core_rvalid_o, ext_rvalid_o);
                n_err++;
            end
        end
        next_cycle(); idle_inputs();
    endtask

    initial begin
        rst_i = 1'b1;
        idle_inputs();
        test_reset();
        test_single_read();
        test_conflict();
        test_back_to_back();
        test_interleave();
        test_spurious();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
